// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the APB round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // One-hot transfer states
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        GRANT = 5'b00010,
        RESP  = 5'b00100,
        ERR   = 5'b01000,
        DRAIN = 5'b10000
    } arb_state_t;

    localparam int ERR_CNT_W = 8;

    // Index width for n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; search starts after last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int GW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [GW-1:0]      last_grant,
    output logic               any,
    output logic [GW-1:0]      grant
);

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return GW'(s);
    endfunction

    // Walk from the farthest candidate to the nearest so the nearest pending one wins.
    always_comb begin
        any   = |pend;
        grant = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (pend[wrap_add(last_grant, off)]) begin
                grant = wrap_add(last_grant, off);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Round-robin arbiter sharing one register-request channel among
//               NUM_REQ APB requesters, with per-transfer timeout and drain.
//               Optional error log enabled by defining ARB_ERR_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ    = 3,
    parameter  int ADDR_WIDTH = 21,
    parameter  int DATA_WIDTH = 16,
    parameter  int TO_WIDTH   = 16,
    localparam int GW         = clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [TO_WIDTH-1:0]           cfg_timeout,
    input  logic [NUM_REQ-1:0]            s_psel,
    input  logic [NUM_REQ-1:0]            s_penable,
    input  logic [NUM_REQ-1:0]            s_pwrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_paddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_pwdata,
    output logic [DATA_WIDTH-1:0]         s_prdata,
    output logic [NUM_REQ-1:0]            s_pready,
    output logic [NUM_REQ-1:0]            s_pslverr,
    output logic                          req_sel,
    output logic                          req_write,
    output logic [ADDR_WIDTH-1:0]         req_addr,
    output logic [DATA_WIDTH-1:0]         req_wdata,
    input  logic                          req_ready,
    input  logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          busy
`ifdef ARB_ERR_LOG_EN
    ,
    input  logic                          err_clr,
    output logic                          err_valid,
    output logic [GW-1:0]                 err_port,
    output logic [ADDR_WIDTH-1:0]         err_addr,
    output logic [ERR_CNT_W-1:0]          err_cnt
`endif
);

    arb_state_t            r_state;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [TO_WIDTH-1:0]   r_cnt;

    logic [NUM_REQ-1:0]    w_pend;
    logic                  w_any;
    logic [GW-1:0]         w_pick;
    logic                  w_to_hit;

    assign w_pend   = s_psel & s_penable;
    assign w_to_hit = (cfg_timeout != '0) && (r_cnt == (cfg_timeout - TO_WIDTH'(1)));

    rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .pend       (w_pend),
        .last_grant (r_last),
        .any        (w_any),
        .grant      (w_pick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_REQ - 1);
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_addr  <= s_paddr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= s_pwdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
                        r_write <= s_pwrite[w_pick];
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_cnt <= r_cnt + TO_WIDTH'(1);
                    // A completion in the expiry cycle still counts as a normal response.
                    if (req_ready) begin
                        r_rdata <= req_rdata;
                        r_state <= RESP;
                    end else if (w_to_hit) begin
                        r_state <= ERR;
                    end
                end
                RESP: begin
                    r_last  <= r_grant;
                    r_state <= IDLE;
                end
                ERR: begin
                    r_last  <= r_grant;
                    r_cnt   <= '0;
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    r_cnt <= r_cnt + TO_WIDTH'(1);
                    // Late response is swallowed here; a cleared timeout must not strand us.
                    if (req_ready || w_to_hit || (cfg_timeout == '0)) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_sel   = (r_state == GRANT);
    assign req_write = r_write;
    assign req_addr  = r_addr;
    assign req_wdata = r_wdata;
    assign busy      = (r_state != IDLE);
    assign s_prdata  = (r_state == RESP) ? r_rdata : '0;

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_pready[i]  = ((r_state == RESP) || (r_state == ERR)) && (r_grant == GW'(i));
            s_pslverr[i] = (r_state == ERR) && (r_grant == GW'(i));
        end
    end

`ifdef ARB_ERR_LOG_EN
    logic                  r_err_valid;
    logic [GW-1:0]         r_err_port;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic                  w_err_entry;

    assign w_err_entry = (r_state == GRANT) && !req_ready && w_to_hit;

    // A clear coinciding with a new timeout restarts the log with that timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_valid <= 1'b0;
            r_err_port  <= '0;
            r_err_addr  <= '0;
            r_err_cnt   <= '0;
        end else if (w_err_entry) begin
            r_err_valid <= 1'b1;
            if (err_clr || !r_err_valid) begin
                r_err_port <= r_grant;
                r_err_addr <= r_addr;
            end
            if (err_clr) begin
                r_err_cnt <= ERR_CNT_W'(1);
            end else if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            r_err_valid <= 1'b0;
            r_err_port  <= '0;
            r_err_addr  <= '0;
            r_err_cnt   <= '0;
        end
    end

    assign err_valid = r_err_valid;
    assign err_port  = r_err_port;
    assign err_addr  = r_err_addr;
    assign err_cnt   = r_err_cnt;
`endif

endmodule : apb_rr_arbiter
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_rr_arbiter
// Description : Self-checking bench: directed vector table, reset and error-log
//               sequences, then randomized transfers against a transfer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 21;
    localparam int DW = 16;
    localparam int TW = 16;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic [TW-1:0]   cfg_timeout;
    logic [N-1:0]    s_psel, s_penable, s_pwrite;
    logic [N*AW-1:0] s_paddr;
    logic [N*DW-1:0] s_pwdata;
    logic [DW-1:0]   s_prdata;
    logic [N-1:0]    s_pready, s_pslverr;
    logic            req_sel, req_write;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic            req_ready;
    logic [DW-1:0]   req_rdata;
    logic            busy;
`ifdef ARB_ERR_LOG_EN
    logic            err_clr;
    logic            err_valid;
    logic [GW-1:0]   err_port;
    logic [AW-1:0]   err_addr;
    logic [7:0]      err_cnt;
`endif

    always #5 clk = ~clk;

    apb_rr_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TO_WIDTH(TW)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_timeout(cfg_timeout),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .req_sel(req_sel), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
        .busy(busy)
`ifdef ARB_ERR_LOG_EN
        , .err_clr(err_clr), .err_valid(err_valid), .err_port(err_port),
        .err_addr(err_addr), .err_cnt(err_cnt)
`endif
    );

    typedef struct {
        logic [N-1:0]  pend;
        int            tmo;
        int            lat;
        int            late;
        logic [DW-1:0] rdata;
        bit            drop;
        int            eg;
        bit            eerr;
        int            esel;
    } vec_t;

    vec_t          tbl [8];
    int            checks   = 0;
    int            failures = 0;
    logic [AW-1:0] a_addr  [N];
    logic [DW-1:0] a_wdata [N];
    logic          a_write [N];
    int            m_last;
    bit            lg_valid;
    int            lg_port;
    logic [AW-1:0] lg_addr;
    int            lg_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_model(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_requests();
        s_psel    = '0;
        s_penable = '0;
    endtask

    task automatic set_requests(input logic [N-1:0] mask, input int tmo);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                a_addr[i]  = AW'($urandom);
                a_wdata[i] = DW'($urandom);
                a_write[i] = 1'($urandom_range(0, 1));
                s_psel[i]    = 1'b1;
                s_penable[i] = 1'b1;
            end else begin
                s_psel[i]    = 1'($urandom_range(0, 1));
                s_penable[i] = 1'b0;
            end
            s_paddr[i*AW +: AW]  = a_addr[i];
            s_pwdata[i*DW +: DW] = a_wdata[i];
            s_pwrite[i]          = a_write[i];
        end
        cfg_timeout = TW'(tmo);
    endtask

    // One complete transfer from the IDLE cycle through to the next IDLE cycle.
    task automatic run_xfer(input logic [N-1:0] mask, input int tmo, input int lat, input int late,
                            input logic [DW-1:0] rdata, input bit drop, input int eg,
                            input bit eerr, input int esel);
        int           drain;
        logic [N-1:0] oh;
        oh     = '0;
        oh[eg] = 1'b1;
        set_requests(mask, tmo);
        chk("idle_busy", busy, 0);
        step();
        for (int c = 1; c <= esel; c++) begin
            chk("req_sel", req_sel, 1);
            chk("req_addr", req_addr, a_addr[eg]);
            chk("req_wdata", req_wdata, a_wdata[eg]);
            chk("req_write", req_write, a_write[eg]);
            chk("pready_early", s_pready, 0);
            if (drop && c == 1) s_psel[eg] = 1'b0;
            if (c == lat) begin
                req_ready = 1'b1;
                req_rdata = rdata;
            end
            step();
            req_ready = 1'b0;
            req_rdata = DW'($urandom);
        end
        chk("req_sel_end", req_sel, 0);
        chk("pready", s_pready, oh);
        chk("pslverr", s_pslverr, eerr ? oh : '0);
        chk("prdata", s_prdata, eerr ? '0 : rdata);
        chk("busy_resp", busy, 1);
        s_psel[eg]    = 1'b0;
        s_penable[eg] = 1'b0;
        m_last        = eg;
        if (eerr) begin
            if (!lg_valid) begin
                lg_valid = 1'b1;
                lg_port  = eg;
                lg_addr  = a_addr[eg];
            end
            if (lg_cnt < 255) lg_cnt++;
        end
        step();
        if (eerr) begin
            drain = (late > 0 && late <= tmo) ? late : tmo;
            for (int d = 1; d <= drain; d++) begin
                chk("drain_sel", req_sel, 0);
                chk("drain_busy", busy, 1);
                chk("drain_pready", s_pready, 0);
                if (d == late) req_ready = 1'b1;
                step();
                req_ready = 1'b0;
            end
        end
        chk("idle_after", busy, 0);
        chk("idle_pready", s_pready, 0);
    endtask

    initial begin
        int            g, tmo, lat, late;
        bit            er;
        logic [N-1:0]  mask;

        tbl[0] = '{3'b111, 16,    4, 0, 16'h1234, 1'b0, 0, 1'b0,    4};
        tbl[1] = '{3'b111, 16,    1, 0, 16'hA5C3, 1'b1, 1, 1'b0,    1};
        tbl[2] = '{3'b111,  5,    9, 2, 16'h0F0F, 1'b0, 2, 1'b1,    5};
        tbl[3] = '{3'b111,  5,    5, 0, 16'h5A5A, 1'b0, 0, 1'b0,    5};
        tbl[4] = '{3'b101,  0, 1000, 0, 16'hBEEF, 1'b0, 2, 1'b0, 1000};
        tbl[5] = '{3'b010,  3,    2, 0, 16'h0001, 1'b0, 1, 1'b0,    2};
        tbl[6] = '{3'b011,  2,    7, 0, 16'hFFFF, 1'b0, 0, 1'b1,    2};
        tbl[7] = '{3'b110, 16,    3, 0, 16'h8000, 1'b0, 1, 1'b0,    3};

        rstn = 1'b1;
        clear_requests();
        s_pwrite = '0; s_paddr = '0; s_pwdata = '0;
        cfg_timeout = '0; req_ready = 1'b0; req_rdata = '0;
`ifdef ARB_ERR_LOG_EN
        err_clr = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0; a_write[i] = 1'b0;
        end
        m_last = N - 1; lg_valid = 1'b0; lg_port = 0; lg_addr = '0; lg_cnt = 0;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_sel", req_sel, 0);
        chk("rst_req_write", req_write, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_wdata", req_wdata, 0);
        chk("rst_prdata", s_prdata, 0);
        chk("rst_pready", s_pready, 0);
        chk("rst_pslverr", s_pslverr, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) rstn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_xfer(tbl[i].pend, tbl[i].tmo, tbl[i].lat, tbl[i].late, tbl[i].rdata,
                     tbl[i].drop, tbl[i].eg, tbl[i].eerr, tbl[i].esel);
        end
        clear_requests();
        step();

`ifdef ARB_ERR_LOG_EN
        chk("log_valid", err_valid, 1);
        chk("log_cnt", err_cnt, 2);
        chk("log_port", err_port, 2);
        chk("log_addr", err_addr, lg_addr);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_valid", err_valid, 0);
        chk("clr_cnt", err_cnt, 0);
        chk("clr_port", err_port, 0);
        chk("clr_addr", err_addr, 0);
`endif
        lg_valid = 1'b0; lg_cnt = 0;

        // Reset in the middle of a grant
        set_requests(3'b111, 16);
        step();
        chk("mid_req_sel", req_sel, 1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_sel", req_sel, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", req_addr, 0);
        chk("mid_rst_wdata", req_wdata, 0);
        chk("mid_rst_write", req_write, 0);
        chk("mid_rst_pready", s_pready, 0);
        chk("mid_rst_pslverr", s_pslverr, 0);
        chk("mid_rst_prdata", s_prdata, 0);
        clear_requests();
        @(negedge clk) rstn = 1'b1;
        step();
        m_last = N - 1; lg_valid = 1'b0; lg_cnt = 0;
        run_xfer(3'b111, 16, 2, 0, 16'h3C3C, 1'b0, 0, 1'b0, 2);

        for (int n = 0; n < 250; n++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            tmo  = $urandom_range(0, 8);
            lat  = (tmo == 0) ? $urandom_range(1, 12) : $urandom_range(1, tmo + 3);
            late = $urandom_range(0, tmo + 2);
            g    = rr_model(mask, m_last);
            er   = (tmo != 0) && (lat > tmo);
            run_xfer(mask, tmo, lat, late, DW'($urandom), ($urandom_range(0, 3) == 0),
                     g, er, er ? tmo : lat);
        end
        clear_requests();
        step();

`ifdef ARB_ERR_LOG_EN
        chk("rand_log_valid", err_valid, lg_valid);
        chk("rand_log_cnt", err_cnt, lg_cnt);
        if (lg_valid) begin
            chk("rand_log_port", err_port, lg_port);
            chk("rand_log_addr", err_addr, lg_addr);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_apb_rr_arbiter
`default_nettype wire
